sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_beat_timer.sv | 35 +++
 rtl/sram_controller.sv | 134 +++++++++++++
 tb/tb_sram_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and widths for the cache-side SRAM controller.
// Holds the FSM encoding, beat counts and the external/internal bus widths.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int READ_BEATS  = 4;
  localparam int WRITE_BEATS = 2;

  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 32;
  localparam int BLOCK_W     = 64;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DQ_W   = 16;

  localparam int BEAT_IDX_W  = 2;
  localparam int WAIT_W      = 3;

endpackage

// File: rtl/sram_beat_timer.sv
// Beat sequencer: each beat lasts SRAM_WAIT+1 cycles; beat_last marks its final cycle.
// Counters clear whenever run is low, so every access starts at beat 0, cycle 0.
module sram_beat_timer
  import sram_pkg::*;
#(
  parameter int SRAM_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  beat_last,
  output logic [BEAT_IDX_W-1:0] beat_idx
);

  logic [WAIT_W-1:0] wait_cnt;

  assign beat_last = run && (wait_cnt == WAIT_W'(SRAM_WAIT));

  // beat_idx wraps naturally, so the half-word index never carries into the block address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      beat_idx <= '0;
    end else if (!run) begin
      wait_cnt <= '0;
      beat_idx <= '0;
    end else if (beat_last) begin
      wait_cnt <= '0;
      beat_idx <= beat_idx + 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Cache-side SRAM controller: 4-beat 8-byte block reads, 2-beat word writes, ready pulses in DONE.
// Latency 4*BEAT+1 (read) / 2*BEAT+1 (write); requests are ignored while an access is in flight.
module sram_controller
  import sram_pkg::*;
#(
  parameter int SRAM_WAIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   read_en,
  input  logic                   write_en,
  output logic [BLOCK_W-1:0]     rdata,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:2]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  run;
  logic                  beat_last;
  logic [BEAT_IDX_W-1:0] beat_idx;
  logic                  dq_oe;
  logic [SRAM_DQ_W-1:0]  dq_out;
  logic                  start;
  logic                  unused_lsb;

  // Byte offset within a half-word pair is irrelevant: writes are whole words.
  assign unused_lsb = ^address[1:0];

  assign run   = (state == READ) || (state == WRITE);
  assign start = (state == IDLE) && (read_en || write_en);

  sram_beat_timer #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_beat_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .beat_last (beat_last),
    .beat_idx  (beat_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      addr_q  <= address[ADDR_W-1:2];
      wdata_q <= wdata;
    end
  end

  // Half-word i lands in rdata[16i +: 16]: little-endian block assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if ((state == READ) && beat_last) begin
      rdata[{beat_idx, 4'b0000} +: SRAM_DQ_W] <= SRAM_DQ;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[SRAM_DQ_W-1:0];
    case (state)
      IDLE: begin
        if (write_en) begin
          state_nxt = WRITE;
        end else if (read_en) begin
          state_nxt = READ;
        end
      end
      READ: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_ADDR = {addr_q[ADDR_W-1:3], beat_idx};
        if (beat_last && (beat_idx == BEAT_IDX_W'(READ_BEATS - 1))) begin
          state_nxt = DONE;
        end
      end
      WRITE: begin
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        // WE_N rises on the last cycle so the SRAM latches with address and data still stable
        SRAM_WE_N = beat_last;
        SRAM_ADDR = {addr_q[ADDR_W-1:2], beat_idx[0]};
        dq_oe     = 1'b1;
        dq_out    = beat_idx[0] ? wdata_q[DATA_W-1:SRAM_DQ_W] : wdata_q[SRAM_DQ_W-1:0];
        if (beat_last && (beat_idx == BEAT_IDX_W'(WRITE_BEATS - 1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign SRAM_DQ = dq_oe ? dq_out : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: two controllers (SRAM_WAIT=1 and 3) each on a behavioural SRAM with a pulled-up bus.
// A floating bus therefore reads 0xFFFF whenever neither side drives it.
module tb_sram_controller;

  logic        clk;
  logic        rst;

  logic [18:0] addr0, addr1;
  logic [31:0] wd0, wd1;
  logic        rd0, rd1, wr0, wr1;
  logic [63:0] rdata0, rdata1;
  logic        rdy0, rdy1;
  wire  [15:0] dq0, dq1;
  logic [17:0] sa0, sa1;
  logic        ce0, oe0, we0, ub0, lb0;
  logic        ce1, oe1, we1, ub1, lb1;

  logic        pl_en0, pl_en1;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  int checks;
  int errors;

  sram_controller #(.SRAM_WAIT(1)) u0 (
    .clk(clk), .rst(rst), .address(addr0), .wdata(wd0), .read_en(rd0), .write_en(wr0),
    .rdata(rdata0), .ready(rdy0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_CE_N(ce0),
    .SRAM_OE_N(oe0), .SRAM_WE_N(we0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
  );

  sram_controller #(.SRAM_WAIT(3)) u1 (
    .clk(clk), .rst(rst), .address(addr1), .wdata(wd1), .read_en(rd1), .write_en(wr1),
    .rdata(rdata1), .ready(rdy1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_CE_N(ce1),
    .SRAM_OE_N(oe1), .SRAM_WE_N(we1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );

  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup (dq0[g]);
    pullup (dq1[g]);
  end

  assign dq0 = (!ce0 && !oe0) ? mem0[sa0[7:0]] : 'z;
  assign dq1 = (!ce1 && !oe1) ? mem1[sa1[7:0]] : 'z;

  always @(posedge clk) begin
    if (pl_en0) mem0[pl_a] <= pl_d;
    else if (!ce0 && !we0) mem0[sa0[7:0]] <= dq0;
    if (pl_en1) mem1[pl_a] <= pl_d;
    else if (!ce1 && !we1) mem1[sa1[7:0]] <= dq1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic preload(input bit sel, input logic [7:0] a, input logic [15:0] d);
    pl_a   = a;
    pl_d   = d;
    pl_en0 = !sel;
    pl_en1 = sel;
    @(negedge clk);
    pl_en0 = 1'b0;
    pl_en1 = 1'b0;
  endtask

  // Called on a negedge just after the request was raised. Walks the access cycle by cycle
  // against an expected strobe/address/data schedule; drops and scrambles the inputs at n==hold.
  task automatic watch(input bit sel, input bit is_wr, input logic [18:0] adr,
                       input logic [31:0] wd, input int hold, input string nm);
    int w, tot, beat, rdy_n;
    bit active, last;
    logic [1:0]  bi;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    w     = sel ? 3 : 1;
    tot   = (is_wr ? 2 : 4) * (w + 1) + 1;
    rdy_n = 0;
    for (int n = 1; n <= tot + 2; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == hold) begin
        if (sel) begin rd1 = 1'b0; wr1 = 1'b0; addr1 = ~adr; wd1 = ~wd; end
        else     begin rd0 = 1'b0; wr0 = 1'b0; addr0 = ~adr; wd0 = ~wd; end
      end
      active = (n < tot);
      beat   = (n - 1) / (w + 1);
      last   = ((n - 1) % (w + 1)) == w;
      bi     = 2'(beat);
      if (!active)    e_addr = '0;
      else if (is_wr) e_addr = {adr[18:2], bi[0]};
      else            e_addr = {adr[18:3], bi};
      e_dq = (active && is_wr) ? (bi[0] ? wd[31:16] : wd[15:0]) : 16'hFFFF;
      if (sel ? rdy1 : rdy0) rdy_n++;
      chk($sformatf("%s n%0d ready", nm, n), 64'(sel ? rdy1 : rdy0), 64'(n == tot));
      chk($sformatf("%s n%0d ce_n", nm, n), 64'(sel ? ce1 : ce0), 64'(!active));
      chk($sformatf("%s n%0d ub_lb", nm, n), 64'(sel ? {ub1, lb1} : {ub0, lb0}),
          64'({!active, !active}));
      chk($sformatf("%s n%0d oe_n", nm, n), 64'(sel ? oe1 : oe0), 64'(!(active && !is_wr)));
      chk($sformatf("%s n%0d we_n", nm, n), 64'(sel ? we1 : we0),
          64'(!(active && is_wr && !last)));
      chk($sformatf("%s n%0d addr", nm, n), 64'(sel ? sa1 : sa0), 64'(e_addr));
      if (!(active && !is_wr))
        chk($sformatf("%s n%0d dq", nm, n), 64'(sel ? dq1 : dq0), 64'(e_dq));
    end
    chk({nm, " ready_count"}, 64'(rdy_n), 64'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    pl_en0 = 1'b0; pl_en1 = 1'b0; pl_a = '0; pl_d = '0;
    @(negedge clk);

    // Byte address 0x2C lies in half-word block 0x14..0x17, so the block data is mirrored there.
    for (int i = 0; i < 4; i++) begin
      preload(1'b0, 8'(8'h04 + i), 16'(16'h1000 + i));
      preload(1'b0, 8'(8'h14 + i), 16'(16'h1000 + i));
      preload(1'b0, 8'(8'h24 + i), 16'(16'h5000 + i));
      preload(1'b1, 8'(8'h14 + i), 16'(16'h2000 + i));
    end

    chk("rst ready", 64'(rdy0), 64'd0);
    chk("rst rdata", rdata0, 64'd0);
    chk("rst strobes", 64'({ce0, oe0, we0, ub0, lb0}), 64'h1F);
    chk("rst addr", 64'(sa0), 64'd0);
    chk("rst dq", 64'(dq0), 64'hFFFF);
    chk("rst strobes w3", 64'({ce1, oe1, we1, ub1, lb1}), 64'h1F);
    rst = 1'b1;

    // Block read: ready 9 cycles after the request
    addr0 = 19'h0002C; rd0 = 1'b1;
    watch(1'b0, 1'b0, 19'h0002C, 32'h0, 1, "rd");
    chk("rd rdata", rdata0, 64'h1003_1002_1001_1000);

    // Word write: ready after 5 cycles, low half first
    addr0 = 19'h00106; wd0 = 32'hDEADBEEF; wr0 = 1'b1;
    watch(1'b0, 1'b1, 19'h00106, 32'hDEADBEEF, 1, "wr");
    chk("wr mem82", 64'(mem0[8'h82]), 64'hBEEF);
    chk("wr mem83", 64'(mem0[8'h83]), 64'hDEAD);
    chk("wr rdata kept", rdata0, 64'h1003_1002_1001_1000);

    // Simultaneous requests: write wins, OE_N never asserted
    addr0 = 19'h00106; wd0 = 32'h12345678; rd0 = 1'b1; wr0 = 1'b1;
    watch(1'b0, 1'b1, 19'h00106, 32'h12345678, 1, "both");
    chk("both mem82", 64'(mem0[8'h82]), 64'h5678);
    chk("both mem83", 64'(mem0[8'h83]), 64'h1234);

    // Request dropped (and address scrambled) mid-access: read still completes from latched address
    addr0 = 19'h00048; rd0 = 1'b1;
    watch(1'b0, 1'b0, 19'h00048, 32'h0, 2, "drop");
    chk("drop rdata", rdata0, 64'h5003_5002_5001_5000);

    // Reset during write beat 1
    addr0 = 19'h00106; wd0 = 32'hCAFEF00D; wr0 = 1'b1;
    @(posedge clk); @(negedge clk);
    wr0 = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mid we_n low", 64'(we0), 64'd0);
    chk("mid addr beat1", 64'(sa0), 64'h00083);
    rst = 1'b0;
    #1;
    chk("mid rst strobes", 64'({ce0, oe0, we0, ub0, lb0}), 64'h1F);
    chk("mid rst dq", 64'(dq0), 64'hFFFF);
    chk("mid rst ready", 64'(rdy0), 64'd0);
    chk("mid rst addr", 64'(sa0), 64'd0);
    chk("mid rst rdata", rdata0, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("post rst n%0d idle", n), 64'({ce0, rdy0}), 64'b10);
    end
    addr0 = 19'h00048; rd0 = 1'b1;
    watch(1'b0, 1'b0, 19'h00048, 32'h0, 1, "post");
    chk("post rdata", rdata0, 64'h5003_5002_5001_5000);

    // SRAM_WAIT=3: read ready at 17, write WE_N low for 3 cycles per beat
    addr1 = 19'h0002C; rd1 = 1'b1;
    watch(1'b1, 1'b0, 19'h0002C, 32'h0, 1, "w3rd");
    chk("w3rd rdata", rdata1, 64'h2003_2002_2001_2000);
    addr1 = 19'h00106; wd1 = 32'hA5A55A5A; wr1 = 1'b1;
    watch(1'b1, 1'b1, 19'h00106, 32'hA5A55A5A, 1, "w3wr");
    chk("w3wr mem82", 64'(mem1[8'h82]), 64'h5A5A);
    chk("w3wr mem83", 64'(mem1[8'h83]), 64'hA5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
